// File: rtl/hsiao_memory_scrubber_pkg.sv
// Shared types and default widths for the Hsiao memory scrubber.
package hsiao_pkg;

  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned CNT_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WRITE,
    DONE
  } scrub_state_e;

endpackage

// File: rtl/hsiao_memory_scrubber_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count up to all-ones and hold there; clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hsiao_memory_scrubber.sv
// Memory scrubber: passes host writes through when idle, otherwise sweeps
// every address once, rewriting single-bit-corrected words and logging
// double-bit errors.
module hsiao_memory_scrubber
  import hsiao_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = hsiao_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = hsiao_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = hsiao_pkg::DEPTH,
  parameter int unsigned CNT_WIDTH  = hsiao_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear_counts,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  host_wr_en,
  output logic                  host_ready,
  input  logic [DATA_WIDTH-1:0] dec_data,
  input  logic                  dec_sec,
  input  logic                  dec_ded,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wr_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sec_count,
  output logic [CNT_WIDTH-1:0]  ded_count,
  output logic                  ded_flag,
  output logic [ADDR_WIDTH-1:0] ded_addr
);

  scrub_state_e          state;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  last_addr;
  logic                  sec_inc;
  logic                  ded_inc;

  // Decode sweep position and error events seen in CHECK.
  always_comb begin
    last_addr = (scan_addr == ADDR_WIDTH'(DEPTH - 1));
    ded_inc   = (state == CHECK) && dec_ded;
    sec_inc   = (state == CHECK) && dec_sec && !dec_ded;
  end

  // Sweep controller with registered busy/done/host_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      scan_addr  <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      host_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= READ;
            scan_addr  <= '0;
            busy       <= 1'b1;
            host_ready <= 1'b0;
          end
        end
        READ: begin
          state <= CHECK;
        end
        CHECK: begin
          // DED wins when both flags are raised: never rewrite it.
          if (dec_sec && !dec_ded) begin
            wr_data <= dec_data;
            state   <= WRITE;
          end else if (last_addr) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            scan_addr <= scan_addr + ADDR_WIDTH'(1);
            state     <= READ;
          end
        end
        WRITE: begin
          if (last_addr) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            scan_addr <= scan_addr + ADDR_WIDTH'(1);
            state     <= READ;
          end
        end
        DONE: begin
          state      <= IDLE;
          host_ready <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          host_ready <= 1'b1;
        end
      endcase
    end
  end

  // Memory port mux: host owns the port only in IDLE.
  always_comb begin
    mem_addr  = scan_addr;
    mem_data  = wr_data;
    mem_wr_en = 1'b0;
    if (state == IDLE) begin
      mem_addr  = host_addr;
      mem_data  = host_data;
      mem_wr_en = host_wr_en;
    end else if (state == WRITE) begin
      mem_wr_en = 1'b1;
    end
  end

  // Sticky DED flag and most recent DED address; clear beats a new DED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ded_flag <= 1'b0;
      ded_addr <= '0;
    end else if (clear_counts) begin
      ded_flag <= 1'b0;
      ded_addr <= '0;
    end else if (ded_inc) begin
      ded_flag <= 1'b1;
      ded_addr <= scan_addr;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_sec_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_inc),
    .clr   (clear_counts),
    .count (sec_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_ded_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (ded_inc),
    .clr   (clear_counts),
    .count (ded_count)
  );

endmodule

// File: doc/hsiao_memory_scrubber.md
Name: hsiao_memory_scrubber

Overview:
- Sequential controller downstream of the Hsiao decoder. It consumes the decoder's data and error flags and owns the write port of the protected memory.
- When idle, host write traffic passes straight through to the memory.
- On a start request, it sweeps every address once. It rewrites words flagged as single-bit-corrected with the corrected data, which removes latent single faults before they can pair into uncorrectable ones.
- Double-bit errors are counted and logged, never rewritten.

Parameters:
- ADDR_WIDTH, 4, memory address width.
- DATA_WIDTH, 8, unencoded data width (the encoder input width).
- DEPTH, 16, number of words swept (addresses 0 .. DEPTH-1).
- CNT_WIDTH, 8, width of the saturating error counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- start  in  1  request a full sweep; sampled only in IDLE.
- clear_counts  in  1  synchronous clear of counters, ded_flag and ded_addr.
- host_addr  in  ADDR_WIDTH  host address.
- host_data  in  DATA_WIDTH  host write data.
- host_wr_en  in  1  host write request.
- host_ready  out  1  1 = host request forwarded this cycle.
- dec_data  in  DATA_WIDTH  corrected data from the decoder.
- dec_sec  in  1  decoder single_error_corrected.
- dec_ded  in  1  decoder double_error_detected.
- mem_addr  out  ADDR_WIDTH  address to the memory (read and write).
- mem_data  out  DATA_WIDTH  data to the encoder.
- mem_wr_en  out  1  memory write enable.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- sec_count  out  CNT_WIDTH  corrected-error count (saturating).
- ded_count  out  CNT_WIDTH  uncorrectable-error count (saturating).
- ded_flag  out  1  sticky: a DED was seen.
- ded_addr  out  ADDR_WIDTH  address of the most recent DED.

Behaviour:
- Reset values:
  - state=IDLE; scan address=0.
  - busy=0, done=0, host_ready=1.
  - sec_count=0, ded_count=0, ded_flag=0, ded_addr=0.
  - Memory outputs follow the IDLE mux, so mem_wr_en = host_wr_en.
- Reset asserted mid-sweep aborts the sweep at once. No write is issued after reset asserts.
- States:
  - IDLE:
    - mem_addr/mem_data/mem_wr_en = host_addr/host_data/host_wr_en; host_ready=1.
    - start=1 moves to READ with scan address=0.
    - A host write in the same cycle as start is performed; the sweep begins next cycle.
  - READ:
    - mem_addr=scan address, mem_wr_en=0, host_ready=0.
    - Lasts one cycle so the read path (memory, fault injector, decoder) settles. Then go to CHECK.
  - CHECK:
    - mem_addr=scan address; dec_* are sampled at the end of this cycle.
    - dec_sec=1 (dec_ded=0): sec_count+1, go to WRITE.
    - dec_ded=1: ded_count+1, ded_flag=1, ded_addr=scan address, no write, advance.
    - Both flags 1: treat as DED.
    - Neither flag: advance.
  - WRITE:
    - One cycle with mem_wr_en=1, mem_addr=scan address, mem_data=dec_data value latched in CHECK. Then advance.
  - Advance: if scan address==DEPTH-1 go to DONE, otherwise increment the address and go to READ. No wrap within a sweep.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- busy=1 in READ, CHECK and WRITE.
- host_ready=0 while busy. Host requests are ignored, not queued; the host holds its request until host_ready=1.
- start while busy or in DONE is ignored.
- Latency: start sampled at edge k → DONE occupies cycle k+1+2*DEPTH+W, where W = number of words rewritten.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- clear_counts wins over a same-cycle increment.
- clear_counts is legal in any state and does not stop a sweep.

Decomposition:
- Shared package hsiao_pkg holds:
  - the state enum (IDLE, READ, CHECK, WRITE, DONE);
  - default width constants ADDR_WIDTH/DATA_WIDTH/DEPTH/CNT_WIDTH.
- One natural sub-module: sat_counter (parameterised width, with inc and clr inputs, where clr has priority). It is instantiated twice, for SEC and DED.

Test Plan:
- Clean sweep: decoder stub returns no flags → no mem_wr_en during the sweep; done at start edge + 33 cycles; sec_count=0, ded_count=0.
- SEC at addr 5, dec_data=0xA5 → exactly one write at addr 5 with data 0xA5; sec_count=1; done at start + 34 cycles; ded_flag=0.
- DED at addr 9, plus SEC+DED together at addr 12 → ded_count=2, ded_addr=12, ded_flag=1, no writes, sec_count=0.
- Host write 0x3C to addr 2 on the start cycle → write forwarded, host_ready=1 that cycle, then 0 until DONE; host_wr_en during the sweep never reaches mem_wr_en.
- SEC flagged on every address for 16 sweeps with CNT_WIDTH=8 → sec_count=255 (saturated); clear_counts on the same cycle as an increment → 0.
- rst=0 asserted mid-WRITE at addr 7 → mem_wr_en drops immediately; all outputs at reset values; after release, state is IDLE and host_ready=1.
